// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: the decoded instruction-queue entry and its default depth.
// Other pipeline blocks import this package; the queue only consumes these definitions.
package rv32i_types;

    localparam int IQ_DEPTH = 8;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [63:0] order;
        logic        valid;
    } iq_entry_t;

endpackage

// File: rtl/iq_ptr_ctr.sv
// Wrap-bit FIFO pointer: increments by one, clears synchronously.
// Latency: new value visible the cycle after the edge. No backpressure (caller gates inc_i).
// Backpressure: none; the owning queue decides when to advance.
module iq_ptr_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    // Clear beats increment so a redirect never leaves a half-advanced pointer.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-issue instruction FIFO, first-word fall-through; flush empties it in one cycle.
// Latency: 1 cycle enqueue-to-visible (0 with IQ_BYPASS_EN on an empty queue).
// Backpressure: registered full/empty/count; enq while full is dropped, deq while empty ignored.
module inst_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = IQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enq,
    input  iq_entry_t                enq_data,
    output logic                     full,
    input  logic                     deq,
    output logic                     deq_valid,
    output iq_entry_t                deq_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic          enq_acc;
    logic          deq_acc;
    logic          byp_vld;
    logic          byp_take;

    iq_entry_t mem_q [DEPTH];

    // Status derives only from the registered pointers, keeping fetch stall off the issue path.
    always_comb begin
        empty = (head_ptr == tail_ptr);
        full  = (head_ptr[IW-1:0] == tail_ptr[IW-1:0]) && (head_ptr[IW] != tail_ptr[IW]);
        count = tail_ptr - head_ptr;
    end

`ifdef IQ_BYPASS_EN
    always_comb begin
        byp_vld  = empty && enq && !flush && !rst;
        byp_take = byp_vld && deq;
    end
`else
    always_comb begin
        byp_vld  = 1'b0;
        byp_take = 1'b0;
    end
`endif

    always_comb begin
        enq_acc = enq && !full && !flush && !byp_take;
        deq_acc = deq && !empty && !flush;
    end

    iq_ptr_ctr #(.W(PW)) u_head (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .inc_i (deq_acc),
        .ptr_o (head_ptr)
    );

    iq_ptr_ctr #(.W(PW)) u_tail (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .inc_i (enq_acc),
        .ptr_o (tail_ptr)
    );

    always_ff @(posedge clk) begin
        if (enq_acc) begin
            mem_q[tail_ptr[IW-1:0]] <= enq_data;
        end
    end

    // Empty queue shows all-zero data so a stale slot can never look valid downstream.
    always_comb begin
        deq_valid = !empty || byp_vld;
        deq_data  = '0;
        if (byp_vld) begin
            deq_data = enq_data;
        end else if (!empty) begin
            deq_data = mem_q[head_ptr[IW-1:0]];
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue at DEPTH=4: table of per-cycle vectors plus a queue-based reference model.
module tb_inst_queue;
    import rv32i_types::*;

    localparam int DEPTH = 4;
`ifdef IQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       enq;
    iq_entry_t  enq_data;
    logic       full;
    logic       deq;
    logic       deq_valid;
    iq_entry_t  deq_data;
    logic       empty;
    logic [2:0] count;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] sb[$];

    typedef struct {
        logic        f;
        logic        e;
        logic        d;
        logic [31:0] pc;
        int          cnt;
        logic        full;
        logic        empty;
    } vec_t;

    vec_t tbl[$];

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .enq       (enq),
        .enq_data  (enq_data),
        .full      (full),
        .deq       (deq),
        .deq_valid (deq_valid),
        .deq_data  (deq_data),
        .empty     (empty),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    function automatic vec_t mk(input logic f, input logic e, input logic d, input logic [31:0] pc,
                                input int cnt, input logic fl, input logic em);
        vec_t v;
        v.f = f; v.e = e; v.d = d; v.pc = pc; v.cnt = cnt; v.full = fl; v.empty = em;
        return v;
    endfunction

    // One clock: drive at negedge, check same-cycle outputs, update model, check after the edge.
    task automatic cycle(input logic f, input logic e, input logic d, input logic [31:0] pc);
        iq_entry_t ent;
        int        n;
        logic      exp_byp;
        @(negedge clk);
        ent       = '0;
        ent.inst  = pc ^ 32'hA5A5_0000;
        ent.pc    = pc;
        ent.order = {32'h0, pc};
        ent.valid = 1'b1;
        flush = f; enq = e; deq = d; enq_data = ent;
        #1;
        n = sb.size();
        if (n == 0) begin
            exp_byp = BYP && e && !f;
            chk("pre_deq_valid", 64'(deq_valid), 64'(exp_byp));
            if (exp_byp) chk("bypass_pc", 64'(deq_data.pc), 64'(pc));
            else         chk("pre_data_zero", 64'(deq_data == '0), 64'd1);
        end else begin
            chk("pre_deq_valid", 64'(deq_valid), 64'd1);
            chk("pre_pc", 64'(deq_data.pc), 64'(sb[0]));
        end
        if (f) begin
            sb.delete();
        end else if (n == 0) begin
            if (e && !(BYP && d)) sb.push_back(pc);
        end else begin
            if (e && n < DEPTH) sb.push_back(pc);
            if (d) void'(sb.pop_front());
        end
        @(posedge clk);
        #1;
        flush = 1'b0; enq = 1'b0; deq = 1'b0;
        #1;
        chk("count", 64'(count), 64'(sb.size()));
        chk("full", 64'(full), 64'(sb.size() == DEPTH));
        chk("empty", 64'(empty), 64'(sb.size() == 0));
        chk("deq_valid", 64'(deq_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) chk("head_pc", 64'(deq_data.pc), 64'(sb[0]));
        else                chk("head_zero", 64'(deq_data == '0), 64'd1);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; enq = 1'b0; deq = 1'b0; enq_data = '0;

        // Fill to full, overflow attempt, drain.
        tbl.push_back(mk(0, 1, 0, 32'h6000_0000, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 32'h6000_0004, 2, 0, 0));
        tbl.push_back(mk(0, 1, 0, 32'h6000_0008, 3, 0, 0));
        tbl.push_back(mk(0, 1, 0, 32'h6000_000C, 4, 1, 0));
        tbl.push_back(mk(0, 1, 0, 32'h6000_0010, 4, 1, 0));
        tbl.push_back(mk(0, 0, 1, 32'h0, 3, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h0, 0, 0, 1));
        // Steady state at count 2 across pointer wrap.
        tbl.push_back(mk(0, 1, 0, 32'h6000_0014, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 32'h6000_0018, 2, 0, 0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0, 1, 1, 32'h6000_001C + 32'(4 * i), 2, 0, 0));
        // Full with simultaneous enq/deq: dequeue only.
        tbl.push_back(mk(0, 1, 0, 32'h6000_0044, 3, 0, 0));
        tbl.push_back(mk(0, 1, 0, 32'h6000_0048, 4, 1, 0));
        tbl.push_back(mk(0, 1, 1, 32'h6000_004C, 3, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h0, 2, 0, 0));
        tbl.push_back(mk(0, 1, 0, 32'h6000_0050, 3, 0, 0));
        // Flush overrides enq/deq, then refill.
        tbl.push_back(mk(1, 1, 1, 32'h6000_0054, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 32'h6000_0100, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h0, 0, 0, 1));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_deq_valid", 64'(deq_valid), 64'd0);
        chk("rst_deq_data", 64'(deq_data == '0), 64'd1);

        foreach (tbl[i]) begin
            cycle(tbl[i].f, tbl[i].e, tbl[i].d, tbl[i].pc);
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].cnt));
            chk($sformatf("vec%0d_full", i), 64'(full), 64'(tbl[i].full));
            chk($sformatf("vec%0d_empty", i), 64'(empty), 64'(tbl[i].empty));
        end

        // Empty queue, enq with deq: bypass consumes same cycle, otherwise visible next cycle.
        cycle(0, 1, 1, 32'h6000_0020);
        chk("byp_count", 64'(count), BYP ? 64'd0 : 64'd1);
        if (sb.size() != 0) cycle(0, 0, 1, 32'h0);
        chk("byp_drained", 64'(empty), 64'd1);

        // Reset mid-operation wins over a same-cycle flush and enq.
        cycle(0, 1, 0, 32'h6000_0200);
        cycle(0, 1, 0, 32'h6000_0204);
        @(negedge clk);
        rst = 1'b1; flush = 1'b1; enq = 1'b1; enq_data.pc = 32'h6000_0208;
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0; enq = 1'b0;
        sb.delete();
        #1;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_empty", 64'(empty), 64'd1);
        chk("midrst_deq_valid", 64'(deq_valid), 64'd0);
        cycle(0, 1, 0, 32'h6000_0300);
        chk("post_rst_pc", 64'(deq_data.pc), 64'h6000_0300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
